hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Companion to the pipeline forwarding logic. It covers the hazards forwarding cannot resolve: a load-use dependency, and a taken-branch wrong-path fetch.
- Sits between the IF/ID and ID/EX stages.
- Drives PC write-enable, IF/ID write-enable, an ID/EX bubble (control-zero) select, and an IF/ID flush.
- A small FSM and counter hold the stall for a parameterised memory latency.

Parameters:
- REG_ADDR_W, 5, register specifier width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..15.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_Rt  in  REG_ADDR_W  load destination register.
- IF_ID_Rs  in  REG_ADDR_W  source register of the instruction in ID.
- IF_ID_Rt  in  REG_ADDR_W  second source register of the instruction in ID.
- IF_ID_UsesRt  in  1  instruction in ID reads rt (R-type, store, branch).
- branch_taken  in  1  branch resolved taken this cycle.
- PCWrite  out  1  1 = PC may advance.
- IF_ID_Write  out  1  1 = IF/ID register may load.
- ID_EX_Bubble  out  1  1 = zero the ID/EX control fields.
- IF_ID_Flush  out  1  1 = clear IF/ID to a NOP.
- stall_active  out  1  FSM in the STALL state.
- stall_count  out  CNT_W  stall cycles counted (optional feature).
- flush_count  out  CNT_W  flushes counted (optional feature).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values, forced while rst_n=0 regardless of other inputs:
  - PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, stall_active=0.
  - FSM=RUN, remaining-stall counter=0, stall_count=0, flush_count=0.
- Hazard term: hz = ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt==IF_ID_Rt)).
- Register 0 never causes a stall.
- FSM states are RUN and STALL.
- RUN:
  - If hz=0: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - If hz=1: in the same cycle (combinational, zero latency) PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - If hz=1 and LOAD_STALL_CYCLES=1: stay in RUN.
  - If hz=1 and LOAD_STALL_CYCLES>1: go to STALL with remaining=LOAD_STALL_CYCLES-1.
- STALL:
  - Outputs PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, stall_active=1.
  - hz is ignored: ID/EX already holds a bubble.
  - remaining decrements each cycle. When remaining==1, the next state is RUN.
  - Total frozen cycles = LOAD_STALL_CYCLES exactly.
- After a stall returns to RUN, hz is evaluated again on the then-current ID/EX contents. Back-to-back load-use chains stall again.
- branch_taken=1 (any state):
  - IF_ID_Flush=1 for that cycle; PCWrite=1 (branch target must load); IF_ID_Write=1; ID_EX_Bubble=1.
  - FSM returns to RUN and remaining is cleared.
  - branch_taken has priority over hz and over STALL.
- A branch held high for N cycles gives N flush cycles. No internal one-shot is applied.
- Reset asserted mid-stall: the next edge enters RUN with reset values; no residual bubble.
- Output rule: outputs are combinational from the FSM state plus current inputs. Only the FSM state, remaining counter and statistics counters are registered.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With the macro:
  - stall_count increments on every cycle with PCWrite=0.
  - flush_count increments on every cycle with IF_ID_Flush=1.
  - Both saturate at 2^CNT_W-1.
  - Both are cleared only by reset.
- Without the macro: both ports are driven constant 0 and no counter flops are inferred. The port list is identical in both builds.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (HZ_RUN, HZ_STALL);
  - REG_ADDR_W;
  - ZERO_REG = 0;
  - a stall-counter width constant sized for LOAD_STALL_CYCLES max 15 (4 bits).
- One sub-module: load_use_compare, holding the pure combinational hz term. It is reused by any future ID-stage dependency check.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ID_EX_MemRead=1 and ID_EX_Rt=IF_ID_Rs=5 -> PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, stall_active=0 throughout.
- Load-use on rs: LOAD_STALL_CYCLES=1, ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle (MemRead=0) all normal.
- Rt gating and $zero:
  - ID_EX_Rt=9, IF_ID_Rt=9, IF_ID_UsesRt=0 -> no stall.
  - ID_EX_Rt=0, IF_ID_Rs=0, MemRead=1 -> no stall.
  - IF_ID_UsesRt=1 with ID_EX_Rt=9, IF_ID_Rt=9 -> stall.
- Multi-cycle: LOAD_STALL_CYCLES=3, hazard on Rt=12 -> 3 consecutive frozen cycles; stall_active=1 in cycles 2-3; RUN on cycle 4.
- Branch aborts stall: LOAD_STALL_CYCLES=3, branch_taken=1 in the 2nd stall cycle -> that cycle IF_ID_Flush=1 and PCWrite=1; stall_active=0 next cycle; no 3rd stall cycle.
- HAZARD_STATS_EN: one 3-cycle stall plus two flush cycles -> stall_count=2 (aborted stall) or 3 (unaborted stall), flush_count=2. A non-stats build reads both counters as 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / branch hazard detection slice.
package hazard_pkg;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;
  // Remaining-stall counter width; covers LOAD_STALL_CYCLES up to 15.
  localparam int STALL_CNT_W = 4;

endpackage

// File: rtl/load_use_compare.sv
// Pure combinational load-use dependency term between ID/EX load and IF/ID sources.
module load_use_compare #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  IF_ID_UsesRt,
  output logic                  hz
);
  import hazard_pkg::*;

  logic dst_nz;
  logic rs_match;
  logic rt_match;

  // $zero is hardwired, so a load targeting it never creates a dependency.
  assign dst_nz   = (ID_EX_Rt != REG_ADDR_W'(ZERO_REG));
  assign rs_match = (ID_EX_Rt == IF_ID_Rs);
  assign rt_match = IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt);
  assign hz       = ID_EX_MemRead && dst_nz && (rs_match || rt_match);

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall / taken-branch flush control between IF/ID and ID/EX.
// Optional statistics counters enabled with `define HAZARD_STATS_EN.
module hazard_detection_unit #(
  parameter int REG_ADDR_W        = hazard_pkg::REG_ADDR_W,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  IF_ID_UsesRt,
  input  logic                  branch_taken,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Bubble,
  output logic                  IF_ID_Flush,
  output logic                  stall_active,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  import hazard_pkg::*;

  hz_state_e              state;
  logic [STALL_CNT_W-1:0] remaining;
  logic                   hz;

  load_use_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .IF_ID_UsesRt  (IF_ID_UsesRt),
    .hz            (hz)
  );

  // Outputs are combinational so a fresh hazard freezes the front end with zero latency.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    stall_active = 1'b0;
    if (rst_n) begin
      stall_active = (state == HZ_STALL);
      if (branch_taken) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else if (state == HZ_STALL || hz) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
    end
  end

  // The first frozen cycle is spent in RUN, so STALL covers the remaining N-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HZ_RUN;
      remaining <= '0;
    end else if (branch_taken) begin
      state     <= HZ_RUN;
      remaining <= '0;
    end else if (state == HZ_RUN) begin
      if (hz && LOAD_STALL_CYCLES > 1) begin
        state     <= HZ_STALL;
        remaining <= STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
      end
    end else begin
      if (remaining <= STALL_CNT_W'(1)) begin
        state     <= HZ_RUN;
        remaining <= '0;
      end else begin
        remaining <= remaining - STALL_CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!PCWrite && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
      if (IF_ID_Flush && flush_count != {CNT_W{1'b1}})
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench: two DUTs (1-cycle and 3-cycle load stall) share stimulus.
module tb_hazard_detection_unit;

  localparam int RW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mr, uses, br;
  logic [RW-1:0] exrt, rs, rt;

  logic pcw1, ifw1, bub1, fl1, sa1;
  logic pcw3, ifw3, bub3, fl3, sa3;
  logic [CW-1:0] sc1, fc1, sc3, fc3;

  always #5 clk = ~clk;

  hazard_detection_unit #(.REG_ADDR_W(RW), .LOAD_STALL_CYCLES(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .ID_EX_MemRead(mr), .ID_EX_Rt(exrt), .IF_ID_Rs(rs),
    .IF_ID_Rt(rt), .IF_ID_UsesRt(uses), .branch_taken(br), .PCWrite(pcw1),
    .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1), .IF_ID_Flush(fl1), .stall_active(sa1),
    .stall_count(sc1), .flush_count(fc1));

  hazard_detection_unit #(.REG_ADDR_W(RW), .LOAD_STALL_CYCLES(3), .CNT_W(CW)) dut3 (
    .clk(clk), .rst_n(rst_n), .ID_EX_MemRead(mr), .ID_EX_Rt(exrt), .IF_ID_Rs(rs),
    .IF_ID_Rt(rt), .IF_ID_UsesRt(uses), .branch_taken(br), .PCWrite(pcw3),
    .IF_ID_Write(ifw3), .ID_EX_Bubble(bub3), .IF_ID_Flush(fl3), .stall_active(sa3),
    .stall_count(sc3), .flush_count(fc3));

  // Expected bits: {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, stall_active}
  typedef struct {
    logic [4:0] e1;
    logic [4:0] e3;
    bit         chk_cnt;
    int         s1, f1, s3, f3;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] FRZ = 5'b00100;
  localparam logic [4:0] STL = 5'b00101;
  localparam logic [4:0] BRR = 5'b11110;
  localparam logic [4:0] BRS = 5'b11111;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, " d1.PCWrite"},      int'(pcw1), int'(e.e1[4]));
        chk({e.name, " d1.IF_ID_Write"},  int'(ifw1), int'(e.e1[3]));
        chk({e.name, " d1.ID_EX_Bubble"}, int'(bub1), int'(e.e1[2]));
        chk({e.name, " d1.IF_ID_Flush"},  int'(fl1),  int'(e.e1[1]));
        chk({e.name, " d1.stall_active"}, int'(sa1),  int'(e.e1[0]));
        chk({e.name, " d3.PCWrite"},      int'(pcw3), int'(e.e3[4]));
        chk({e.name, " d3.IF_ID_Write"},  int'(ifw3), int'(e.e3[3]));
        chk({e.name, " d3.ID_EX_Bubble"}, int'(bub3), int'(e.e3[2]));
        chk({e.name, " d3.IF_ID_Flush"},  int'(fl3),  int'(e.e3[1]));
        chk({e.name, " d3.stall_active"}, int'(sa3),  int'(e.e3[0]));
        if (e.chk_cnt) begin
          chk({e.name, " d1.stall_count"}, int'(sc1), e.s1);
          chk({e.name, " d1.flush_count"}, int'(fc1), e.f1);
          chk({e.name, " d3.stall_count"}, int'(sc3), e.s3);
          chk({e.name, " d3.flush_count"}, int'(fc3), e.f3);
        end
      end
    end
  end

  task automatic step(input logic r, input logic m, input int ert, input int s,
                      input int t, input logic u, input logic b,
                      input logic [4:0] e1, input logic [4:0] e3, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; mr = m; exrt = RW'(ert); rs = RW'(s); rt = RW'(t); uses = u; br = b;
    e.e1 = e1; e.e3 = e3; e.chk_cnt = 1'b0;
    e.s1 = 0; e.f1 = 0; e.s3 = 0; e.f3 = 0; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic cnt_expect(input int s1, input int f1, input int s3, input int f3);
    exp_t e;
    e = exp_q.pop_back();
`ifdef HAZARD_STATS_EN
    e.s1 = s1; e.f1 = f1; e.s3 = s3; e.f3 = f3;
`else
    e.s1 = 0 * s1; e.f1 = 0 * f1; e.s3 = 0 * s3; e.f3 = 0 * f3;
`endif
    e.chk_cnt = 1'b1;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; mr = 1'b0; uses = 1'b0; br = 1'b0; exrt = '0; rs = '0; rt = '0;
    //    rst mr ert rs rt us br  dut1 dut3
    step(0, 1,  5, 5, 0, 0, 0, NRM, NRM, "reset_a");
    step(0, 1,  5, 5, 0, 0, 0, NRM, NRM, "reset_b");
    step(1, 0,  0, 0, 0, 0, 0, NRM, NRM, "idle");
    step(1, 1,  8, 8, 0, 0, 0, FRZ, FRZ, "lu_rs");
    step(1, 0,  0, 0, 0, 0, 0, NRM, STL, "lu_rs+1");
    step(1, 0,  0, 0, 0, 0, 0, NRM, STL, "lu_rs+2");
    step(1, 0,  0, 0, 0, 0, 0, NRM, NRM, "lu_rs+3");
    step(1, 1,  9, 3, 9, 0, 0, NRM, NRM, "rt_unused");
    step(1, 1,  0, 0, 0, 0, 0, NRM, NRM, "zero_reg");
    step(1, 1,  9, 3, 9, 1, 0, FRZ, FRZ, "rt_used");
    step(1, 0,  0, 0, 0, 0, 0, NRM, STL, "rt_used+1");
    step(1, 1, 12,12, 0, 0, 0, FRZ, STL, "stall_ignores_hz");
    step(1, 1, 12,12, 0, 0, 0, FRZ, FRZ, "back_to_back");
    step(1, 0,  0, 0, 0, 0, 1, BRR, BRS, "branch_abort");
    step(1, 0,  0, 0, 0, 0, 0, NRM, NRM, "after_abort");
    step(1, 1,  7, 7, 0, 0, 1, BRR, BRR, "branch_over_hz");
    step(1, 0,  0, 0, 0, 0, 0, NRM, NRM, "after_branch");
    step(1, 1,  4, 4, 0, 0, 0, FRZ, FRZ, "pre_reset_stall");
    step(0, 0,  0, 0, 0, 0, 0, NRM, NRM, "reset_mid_stall");
    step(1, 0,  0, 0, 0, 0, 0, NRM, NRM, "post_reset");
    cnt_expect(0, 0, 0, 0);
    step(1, 1, 12, 0,12, 1, 0, FRZ, FRZ, "stat_stall");
    step(1, 0,  0, 0, 0, 0, 0, NRM, STL, "stat_stall+1");
    step(1, 0,  0, 0, 0, 0, 0, NRM, STL, "stat_stall+2");
    step(1, 0,  0, 0, 0, 0, 1, BRR, BRR, "stat_flush_a");
    step(1, 0,  0, 0, 0, 0, 1, BRR, BRR, "stat_flush_b");
    step(1, 0,  0, 0, 0, 0, 0, NRM, NRM, "stat_done");
    cnt_expect(1, 2, 3, 2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
